// File: rtl/bsg_circular_ptr_wrap_pkg.sv
// Shared width helper and the operation encoding used by the circular pointer.
// The macro is guarded so that a project-wide bsg_defines can supply it instead.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

package bsg_circular_ptr_wrap_pkg;

   // What the pointer does this cycle, in priority order.
   typedef enum logic [1:0] {
      PTR_OP_RESET = 2'd0,
      PTR_OP_SET   = 2'd1,
      PTR_OP_ADD   = 2'd2
   } ptr_op_e;

   // True when the ring exactly fills the pointer width, so the wrap is the
   // carry out of the sum. slots=1 is excluded: it needs a 1-bit pointer
   // but holds only one slot.
   function automatic bit is_carry_wrap(input int slots, input int width);
      return (slots > 1) && (slots == (1 << width));
   endfunction

endpackage

// File: rtl/bsg_circular_ptr_wrap.sv
// Circular pointer over slots_p slots with a wrap-phase bit.
// Advances by 0..max_add_p per cycle. Supports a synchronous absolute load.
// n_o/n_wrap_o/wrapped_o are the combinational next state. o/wrap_o are registered.
module bsg_circular_ptr_wrap
   import bsg_circular_ptr_wrap_pkg::*;
#(
   parameter int  slots_p      = 16,
   parameter int  max_add_p    = 1,
   localparam int ptr_width_lp = `BSG_SAFE_CLOG2(slots_p),
   localparam int add_width_lp = `BSG_SAFE_CLOG2(max_add_p + 1)
) (
   input  logic                    clk,
   input  logic                    reset_i,
   input  logic [add_width_lp-1:0] add_i,
   input  logic                    set_v_i,
   input  logic [ptr_width_lp-1:0] set_ptr_i,
   input  logic                    set_wrap_i,
   output logic [ptr_width_lp-1:0] o,
   output logic                    wrap_o,
   output logic [ptr_width_lp-1:0] n_o,
   output logic                    n_wrap_o,
   output logic                    wrapped_o
);

   // The sum carries one extra bit so that ptr + add cannot overflow before the compare.
   localparam int sum_width_lp = ptr_width_lp + 1;

   typedef logic [ptr_width_lp-1:0] ptr_t;
   typedef logic [sum_width_lp-1:0] sum_t;
   typedef logic [add_width_lp-1:0] add_t;

   localparam sum_t slots_c   = sum_t'(slots_p);
   localparam add_t max_add_c = add_t'(max_add_p);

   // Refuse parameter sets for which a single subtraction cannot bring the sum back into range.
   if (slots_p < 1 || max_add_p > slots_p || max_add_p < 1) begin : g_bad_params
      $error("bsg_circular_ptr_wrap: need slots_p >= 1 and 1 <= max_add_p <= slots_p");
   end

   ptr_t    ptr_q, ptr_d;
   logic    wrap_q, wrap_d;
   logic    wrapped;
   sum_t    sum;
   ptr_t    add_ptr;
   logic    add_cross;
   ptr_op_e op;

   assign sum = {1'b0, ptr_q} + sum_t'(add_i);

   if (is_carry_wrap(slots_p, ptr_width_lp)) begin : g_pow2
      // Power-of-two ring: the wrap is the carry, and the low bits are already the modulo.
      always_comb begin
         add_cross = sum[ptr_width_lp];
         add_ptr   = sum[ptr_width_lp-1:0];
      end
   end else begin : g_generic
      // Generic ring: one compare and subtract. max_add_p <= slots_p keeps sum < 2*slots_p.
      always_comb begin
         add_cross = (sum >= slots_c);
         add_ptr   = add_cross ? ptr_t'(sum - slots_c) : sum[ptr_width_lp-1:0];
      end
   end

   // Decode which operation wins this cycle: reset, then load, then add.
   always_comb begin
      // NOTE: combinational blocks use blocking '=' so later lines see earlier results.
      op = PTR_OP_ADD;
      if (reset_i) begin
         op = PTR_OP_RESET;
      end else if (set_v_i) begin
         op = PTR_OP_SET;
      end
   end

   // Compute the next pointer, the next wrap phase and the wrap strobe for the chosen operation.
   always_comb begin
      // NOTE: every output gets a default first, so no path can leave it unassigned and infer a latch.
      ptr_d   = ptr_q;
      wrap_d  = wrap_q;
      wrapped = 1'b0;
      unique case (op)
         PTR_OP_RESET: begin
            ptr_d  = '0;
            wrap_d = 1'b0;
         end
         PTR_OP_SET: begin
            ptr_d  = set_ptr_i;
            wrap_d = set_wrap_i;
         end
         default: begin
            ptr_d   = add_ptr;
            wrap_d  = wrap_q ^ add_cross;
            wrapped = add_cross;
         end
      endcase
   end

   // State register. It loads the next state every cycle. Reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
      if (reset_i) begin
         ptr_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         wrap_q <= wrap_d;
      end
   end

   assign o         = ptr_q;
   assign wrap_o    = wrap_q;
   assign n_o       = ptr_d;
   assign n_wrap_o  = wrap_d;
   assign wrapped_o = wrapped;

   // Input legality checks for simulation. Illegal inputs have no defined hardware result.
   add_legal_a : assert property (@(posedge clk) disable iff (reset_i)
                                  add_i <= max_add_c)
      else $error("bsg_circular_ptr_wrap: add_i exceeds max_add_p");

   set_legal_a : assert property (@(posedge clk) disable iff (reset_i)
                                  set_v_i |-> ({1'b0, set_ptr_i} < slots_c))
      else $error("bsg_circular_ptr_wrap: set_ptr_i out of range");

endmodule
